rr_arb_funnel: RTL
==================

Name: rr_arb_funnel

Overview:
- Round-robin arbiter and funnel. It shares one val/rdy output channel between p_nreqs val/rdy requesters.
- Each cycle it picks one requester, drives the select of an internal message mux, and forwards that requester's message downstream.
- Typical uses: the processor merging imem/dmem request streams, or multiple producers onto one memory port.
- The grant stays locked while the output is stalled, so the message stays stable under back-pressure.

Parameters:
- p_nreqs, 4, number of requesters (legal range 2..8).
- p_nbits, 32, message width in bits.
- c_sel_nbits (localparam), $clog2(p_nreqs), width of the grant index.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_val  input  p_nreqs  per-requester valid.
- in_rdy  output  p_nreqs  per-requester ready; one-hot or zero.
- in_msg  input  p_nreqs*p_nbits  concatenated messages; requester i occupies bits [i*p_nbits +: p_nbits].
- out_val  output  1  downstream valid.
- out_rdy  input  1  downstream ready.
- out_msg  output  p_nbits  message of the granted requester.
- grant_sel  output  c_sel_nbits  index of the current grant (observability and debug).

Behaviour:
- Interface decision: one clock, clk. Reset port reset is asynchronous and active-high. State clears immediately when reset rises, regardless of clk.
- State registers:
  - ptr (c_sel_nbits): highest-priority index.
  - locked (1 bit).
  - held (c_sel_nbits): locked grant index.
- Reset values: ptr=0, locked=0, held=0.
- While reset is high: out_val=0, in_rdy=0, grant_sel=0, out_msg=in_msg of requester 0 (don't-care).
- Two states:
  - ARB (locked=0): the grant is the first i with in_val[i]=1, searching ptr, ptr+1, ... modulo p_nreqs. Search wraps past p_nreqs-1 to 0 (for example, with p_nreqs=3, ptr=2 searches order 2,0,1).
  - LOCKED (locked=1): grant=held. in_val of the other requesters is ignored.
- Outputs are combinational from state and inputs:
  - out_val = locked | (|in_val).
  - grant_sel = grant.
  - out_msg = in_msg slice[grant].
  - in_rdy[i] = out_val & out_rdy & (grant==i).
- No latency: a message is presented downstream in the same cycle its in_val rises (zero-cycle funnel, no storage).
- Transfer is defined as out_val & out_rdy. On the clock edge after a transfer:
  - ptr <= (grant+1) mod p_nreqs, with a non-power-of-two wrap, e.g. p_nreqs=3: ptr 2 -> 0.
  - locked <= 0.
- On out_val & !out_rdy: locked <= 1, held <= grant. ptr is unchanged.
- On no out_val: state is unchanged.
- Simultaneous requests are served strictly in rotating order. No requester waits more than p_nreqs-1 transfers once valid.
- Requester protocol obligation: once in_val[i] is asserted it stays high with a stable message until in_rdy[i]. Dropping in_val[i] while it is held in LOCKED is a protocol violation. The bench asserts on it; the RTL need not recover.
- Reset mid-operation (including while LOCKED) returns to ARB with ptr=0 asynchronously. Any in-flight un-transferred message is not consumed (its in_rdy was never seen high).
- The message select is built from one vc_MuxN-style case on grant. Out-of-range indices drive X in simulation.
- Width rule: ptr increment is computed at c_sel_nbits+1 bits, then reduced modulo p_nreqs.

Test Plan:
- Reset/idle: hold reset high, pulse clk, drive in_val=4'b1111 -> out_val=0, in_rdy=0. After reset falls with in_val=0: out_val=0, grant_sel=0.
- Single requester: in_val=4'b0100, msg2=0xCAFE0002, out_rdy=1 -> same cycle out_val=1, out_msg=0xCAFE0002, in_rdy=4'b0100, grant_sel=2. Next cycle ptr=3.
- Round-robin fairness: all four valid, out_rdy=1 for 8 cycles with msg_i=0x100+i -> grant_sel sequence 0,1,2,3,0,1,2,3 and out_msg 0x100..0x103 repeating.
- Back-pressure lock: ptr=0, in_val=4'b0010, out_rdy=0 for 3 cycles, then raise in_val[0] -> grant stays 1 and out_msg stays msg1. Raise out_rdy -> requester 1 transfers, then requester 0 is granted the next cycle.
- Wrap and skip: p_nreqs=3, ptr=2, in_val=3'b011, out_rdy=1 -> grant 0 then 1. ptr sequence 2 -> 1 -> 2.
- Async reset while LOCKED: locked on requester 3 with out_rdy=0, assert reset between clock edges -> out_val and in_rdy drop immediately. After release, in_val=4'b1001 grants 0 first.

Source files
------------

// File: rtl/rr_arb_funnel.sv
// Round-robin arbiter and zero-latency funnel: merges p_nreqs val/rdy requesters onto one
// output channel, locking the grant while the output is back-pressured.
module rr_arb_funnel #(
  parameter int unsigned p_nreqs = 4,
  parameter int unsigned p_nbits = 32,
  localparam int unsigned c_sel_nbits = $clog2(p_nreqs)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [p_nreqs-1:0]         in_val,
  output logic [p_nreqs-1:0]         in_rdy,
  input  logic [p_nreqs*p_nbits-1:0] in_msg,
  output logic                       out_val,
  input  logic                       out_rdy,
  output logic [p_nbits-1:0]         out_msg,
  output logic [c_sel_nbits-1:0]     grant_sel
);

  localparam logic [c_sel_nbits:0] c_nreqs_w = (c_sel_nbits + 1)'(p_nreqs);

  logic [c_sel_nbits-1:0] ptr_q, ptr_d;
  logic [c_sel_nbits-1:0] held_q, held_d;
  logic                   locked_q, locked_d;

  logic [c_sel_nbits-1:0] arb_grant;
  logic [c_sel_nbits-1:0] grant;
  logic [c_sel_nbits:0]   idx_w;
  logic [c_sel_nbits:0]   inc_w;
  logic                   found;
  logic                   xfer;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q    <= '0;
      locked_q <= 1'b0;
      held_q   <= '0;
    end else begin
      ptr_q    <= ptr_d;
      locked_q <= locked_d;
      held_q   <= held_d;
    end
  end

  // Rotating priority search starting at ptr, wrapping modulo p_nreqs
  always_comb begin
    arb_grant = '0;
    found     = 1'b0;
    idx_w     = '0;
    for (int k = 0; k < int'(p_nreqs); k++) begin
      idx_w = {1'b0, ptr_q} + (c_sel_nbits + 1)'(k);
      if (idx_w >= c_nreqs_w) idx_w = idx_w - c_nreqs_w;
      if (!found && in_val[idx_w[c_sel_nbits-1:0]]) begin
        found     = 1'b1;
        arb_grant = idx_w[c_sel_nbits-1:0];
      end
    end
  end

  // Next-state
  always_comb begin
    ptr_d    = ptr_q;
    locked_d = locked_q;
    held_d   = held_q;
    inc_w    = {1'b0, grant} + (c_sel_nbits + 1)'(1);
    if (xfer) begin
      ptr_d    = (inc_w == c_nreqs_w) ? '0 : inc_w[c_sel_nbits-1:0];
      locked_d = 1'b0;
    end else if (out_val) begin
      locked_d = 1'b1;
      held_d   = grant;
    end
  end

  // Outputs; reset masks the combinational request path so nothing leaks while it is high
  always_comb begin
    grant   = locked_q ? held_q : arb_grant;
    out_val = locked_q | (|in_val);
    if (reset) begin
      grant   = '0;
      out_val = 1'b0;
    end
    xfer    = out_val & out_rdy;
    out_msg = 'x;
    in_rdy  = '0;
    for (int i = 0; i < int'(p_nreqs); i++) begin
      if (int'(grant) == i) begin
        out_msg   = in_msg[i*p_nbits +: p_nbits];
        in_rdy[i] = xfer;
      end
    end
  end

  assign grant_sel = grant;

endmodule
